// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - round-robin arbiter feeding one seven-segment display driver
//
// Three requesters compete for a shared seven-segment display. The winner's
// 32-bit word (eight nibbles) is latched into o_data and announced to the
// driver with a one-cycle o_cs strobe. The display is then held for DWELL
// cycles before the next arbitration.
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   reset   synchronous active-high reset
//   req     [2:0] level request per requester (bit 0 = requester 0)
//   data0-2 [31:0] display word of each requester
//   gnt     [2:0] one-hot grant pulse, coincident with o_cs
//   o_cs    one-cycle load strobe for the display driver
//   o_data  [31:0] registered display word, stable between grants
//   busy    high during the grant cycle and the dwell period
module seg7_display_arbiter #(
  parameter int unsigned DWELL = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [2:0]  gnt,
  output logic        o_cs,
  output logic [31:0] o_data,
  output logic        busy
);

  localparam logic [31:0] DWELL_M1 = 32'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t      state;
  logic [1:0]  last_gnt;
  logic [1:0]  win;
  logic [31:0] cnt;

  // Search order starts one past the last winner, wrapping modulo 3.
  logic [1:0]  first, second, third;
  logic [1:0]  pick;
  logic [31:0] pick_data;

  always_comb begin
    first  = 2'd0;
    second = 2'd1;
    third  = 2'd2;
    case (last_gnt)
      2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
  end

  always_comb begin
    pick = third;
    if (req[first])
      pick = first;
    else if (req[second])
      pick = second;
  end

  always_comb begin
    pick_data = data0;
    case (pick)
      2'd1:    pick_data = data1;
      2'd2:    pick_data = data2;
      default: pick_data = data0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      o_cs     <= 1'b0;
      busy     <= 1'b0;
      o_data   <= 32'h0;
      cnt      <= 32'h0;
      last_gnt <= 2'd2;
      win      <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          gnt  <= 3'b000;
          o_cs <= 1'b0;
          if (req != 3'b000) begin
            // Outputs are registered, so the strobe and grant are set here
            // to appear during the GRANT cycle itself.
            win    <= pick;
            o_data <= pick_data;
            gnt    <= 3'b001 << pick;
            o_cs   <= 1'b1;
            busy   <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          gnt      <= 3'b000;
          o_cs     <= 1'b0;
          last_gnt <= win;
          cnt      <= DWELL_M1;
          state    <= HOLD;
        end
        HOLD: begin
          // Counter runs DWELL-1 down to 0, giving exactly DWELL hold cycles.
          if (cnt == 32'h0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 32'h1;
          end
        end
        default: begin
          gnt   <= 3'b000;
          o_cs  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb/tb_seg7_display_arbiter.sv - directed self-checking bench for seg7_display_arbiter
module tb_seg7_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [31:0] data0, data1, data2;
  logic [2:0]  gnt;
  logic        o_cs;
  logic [31:0] o_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_display_arbiter #(.DWELL(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .data0  (data0),
    .data1  (data1),
    .data2  (data2),
    .gnt    (gnt),
    .o_cs   (o_cs),
    .o_data (o_data),
    .busy   (busy)
  );

  // Advance one cycle; observation point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] exp_gnt;

    reset = 1'b1;
    req   = 3'b000;
    data0 = 32'h0;
    data1 = 32'h0;
    data2 = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_gnt",    32'(gnt),  32'h0);
    chk("rst_cs",     32'(o_cs), 32'h0);
    chk("rst_busy",   32'(busy), 32'h0);
    chk("rst_data",   o_data,    32'h0);

    // Single request, then data change ignored during GRANT/HOLD
    reset = 1'b0;
    req   = 3'b001;
    data0 = 32'h12345678;
    step();
    chk("t1_cs",   32'(o_cs), 32'h1);
    chk("t1_gnt",  32'(gnt),  32'h1);
    chk("t1_data", o_data,    32'h12345678);
    chk("t1_busy", 32'(busy), 32'h1);
    req   = 3'b000;
    data0 = 32'hDEADBEEF;
    for (int c = 2; c <= 5; c++) begin
      step();
      chk($sformatf("t1_busy_c%0d", c), 32'(busy), 32'h1);
      chk($sformatf("t1_cs_c%0d", c),   32'(o_cs), 32'h0);
      chk($sformatf("t1_hold_c%0d", c), o_data,    32'h12345678);
    end
    step();
    chk("t1_busy_c6", 32'(busy), 32'h0);
    chk("t1_cs_c6",   32'(o_cs), 32'h0);
    chk("t1_data_c6", o_data,    32'h12345678);
    step();
    chk("t1_idle_gnt",  32'(gnt), 32'h0);
    chk("t1_idle_data", o_data,   32'h12345678);

    // Persistent req=111 round robin, then req=101 from cycle 19
    reset = 1'b1;
    step();
    reset = 1'b0;
    data0 = 32'hA0A0A0A0;
    data1 = 32'hB1B1B1B1;
    data2 = 32'hC2C2C2C2;
    req   = 3'b111;
    for (int c = 1; c <= 31; c++) begin
      step();
      case (c)
        1, 19, 31: exp_gnt = 3'b001;
        7:         exp_gnt = 3'b010;
        13, 25:    exp_gnt = 3'b100;
        default:   exp_gnt = 3'b000;
      endcase
      chk($sformatf("rr_gnt_c%0d", c), 32'(gnt),  32'(exp_gnt));
      chk($sformatf("rr_cs_c%0d", c),  32'(o_cs), (exp_gnt != 3'b000) ? 32'h1 : 32'h0);
      if (c == 7)  chk("rr_data_c7",  o_data, 32'hB1B1B1B1);
      if (c == 13) chk("rr_data_c13", o_data, 32'hC2C2C2C2);
      if (c == 19) begin
        chk("rr_data_c19", o_data, 32'hA0A0A0A0);
        req = 3'b101;
      end
    end

    // Reset in IDLE with a pending request: no strobe follows
    step();
    step();
    step();
    step();
    step();
    reset = 1'b1;
    req   = 3'b001;
    step();
    chk("rst_idle_cs",   32'(o_cs), 32'h0);
    chk("rst_idle_busy", 32'(busy), 32'h0);

    // Reset during HOLD, then req=110 -> requester 1 wins first
    reset = 1'b0;
    req   = 3'b001;
    data0 = 32'h12345678;
    step();
    chk("t4_gnt", 32'(gnt), 32'h1);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("t4_rst_busy", 32'(busy), 32'h0);
    chk("t4_rst_data", o_data,    32'h0);
    chk("t4_rst_cs",   32'(o_cs), 32'h0);
    reset = 1'b0;
    req   = 3'b110;
    data1 = 32'h55AA55AA;
    step();
    chk("t4_gnt2",  32'(gnt), 32'h2);
    chk("t4_data2", o_data,   32'h55AA55AA);

    // Request dropped during HOLD: no further grant, o_data retained
    req = 3'b010;
    step();
    req   = 3'b000;
    data1 = 32'h00000000;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("t5_cs_%0d", c),   32'(o_cs), 32'h0);
      chk($sformatf("t5_gnt_%0d", c),  32'(gnt),  32'h0);
      chk($sformatf("t5_data_%0d", c), o_data,    32'h55AA55AA);
    end
    chk("t5_busy_end", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_display_arbiter.md
SEG7_DISPLAY_ARBITER -- requirements
Module: seg7_display_arbiter

Interface
REQ-001 Parameter DWELL, default 50000000: number of clock cycles the display is held after each grant; legal range is 1 to 2^32-1.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  3  level request per requester; bit 0 = requester 0.
REQ-005 data0 / data1 / data2  input  32 each  eight-nibble display word of each requester.
REQ-006 gnt  output  3  one-hot grant pulse, one cycle long, marking which requester's word was taken.
REQ-007 o_cs  output  1  one-cycle load strobe for the seven-segment display driver.
REQ-008 o_data  output  32  display word for the driver; registered and stable between grants.
REQ-009 busy  output  1  high while a grant/dwell period is in progress.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, GRANT, HOLD.
REQ-011 IDLE with req==0: stay in IDLE; all outputs hold their values except gnt and o_cs, which are 0.
REQ-012 IDLE with req!=0 (cycle T): pick winner W round-robin, searching from last_gnt+1 modulo 3; capture data_W into o_data at the edge ending T; go to GRANT.
REQ-013 GRANT (cycle T+1): o_cs=1 and gnt[W]=1 for exactly this cycle; o_data=captured word; last_gnt<=W; load dwell counter with DWELL-1; go to HOLD.
REQ-014 HOLD: decrement the counter each cycle; when it is 0, go to IDLE; HOLD lasts exactly DWELL cycles (T+2 .. T+1+DWELL).
REQ-015 Arbitration may occur in the first IDLE cycle after HOLD, so the minimum grant-to-grant spacing is DWELL+2 cycles.
REQ-016 busy SHALL be 1 in GRANT and HOLD and 0 in IDLE.
REQ-017 req and data SHALL be sampled only in IDLE; changes during GRANT/HOLD are ignored.
REQ-018 A requester that drops req before its arbitration cycle receives no grant.
REQ-019 gnt SHALL be one-hot or zero in every cycle; gnt!=0 if and only if o_cs==1.
REQ-020 Round-robin order with persistent requests: 0 -> 1 -> 2 -> 0; a non-requesting index is skipped.
REQ-021 The dwell counter is 32 bits wide; no wrap-around occurs because the counter reloads only in GRANT.

Reset
REQ-022 On reset=1 at a rising edge: state=IDLE, gnt=0, o_cs=0, busy=0, o_data=32'h0, counter=0, last_gnt=2 (so requester 0 wins first).
REQ-023 Reset SHALL take priority over all other activity, including mid-GRANT or mid-HOLD; no o_cs is issued in the cycle after reset is asserted.

Verification (DWELL=4)
REQ-024 Reset, then req=001, data0=32'h12345678 at cycle 0 -> cycle 1: o_cs=1, gnt=001, o_data=32'h12345678; busy=1 in cycles 1-5; busy=0 in cycle 6.
REQ-025 req=111 held constantly from cycle 0 -> gnt pulses 001, 010, 100, 001 at cycles 1, 7, 13, 19.
REQ-026 After a grant to requester 0, req=101 -> next grant is 100 and the one after is 001.
REQ-027 Reset asserted in HOLD cycle 3 -> next cycle busy=0, o_data=0; with req=110 afterwards -> first grant is 010.
REQ-028 data0 changed to 32'hDEADBEEF during GRANT/HOLD -> o_data stays 32'h12345678 until the next grant.
REQ-029 req=010 dropped during HOLD and req=000 at IDLE -> no o_cs and no gnt; o_data keeps its last value.
